// File: rtl/laser_interlock_ctrl_pkg.sv
// laser_intlk_pkg: shared state encodings, fault bit indices and timer sizing for laser_interlock_ctrl
package laser_intlk_pkg;
  localparam logic [2:0] ST_DISARMED = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;
  localparam logic [2:0] ST_TRIPPED  = 3'd2;
  localparam logic [2:0] ST_CLEARING = 3'd3;
  localparam logic [2:0] ST_HOLDOFF  = 3'd4;
  localparam int FLT_PW_LO = 0;
  localparam int FLT_PW_HI = 1;
  localparam int FLT_RATE  = 2;
  typedef enum logic [2:0] {
    S_DISARMED = ST_DISARMED,
    S_ARMED    = ST_ARMED,
    S_TRIPPED  = ST_TRIPPED,
    S_CLEARING = ST_CLEARING,
    S_HOLDOFF  = ST_HOLDOFF
  } state_t;
  // one timer serves both CLEARING and HOLDOFF, so size it for the longer of the two
  function automatic int tmr_w(input int a, input int b);
    return $clog2(a > b ? a : b);
  endfunction
endpackage

// File: rtl/laser_interlock_ctrl_if.sv
// laser_interlock_ctrl_if: request/fail inputs and interlock outputs of laser_interlock_ctrl
//   master: drives arm_req, clear_req, *_limit_fail; observes the status outputs
//   slave : the controller side
//   CNT_W : width of fault_cnt_{lo,hi,rate}, present only with LASER_INTLK_FAULT_CNT_EN
interface laser_interlock_ctrl_if #(parameter int CNT_W = 8);
  logic arm_req;
  logic clear_req;
  logic pulse_lower_limit_fail;
  logic pulse_upper_limit_fail;
  logic rate_lower_limit_fail;
  logic laser_enable;
  logic clear_fail;
  logic [2:0] first_fault;
  logic [2:0] fault_status;
  logic clear_timeout;
  logic [2:0] state_out;
`ifdef LASER_INTLK_FAULT_CNT_EN
  logic [CNT_W-1:0] fault_cnt_lo;
  logic [CNT_W-1:0] fault_cnt_hi;
  logic [CNT_W-1:0] fault_cnt_rate;
  modport master(output arm_req, clear_req, pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail,
                 input laser_enable, clear_fail, first_fault, fault_status, clear_timeout, state_out,
                 fault_cnt_lo, fault_cnt_hi, fault_cnt_rate);
  modport slave(input arm_req, clear_req, pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail,
                output laser_enable, clear_fail, first_fault, fault_status, clear_timeout, state_out,
                fault_cnt_lo, fault_cnt_hi, fault_cnt_rate);
`else
  modport master(output arm_req, clear_req, pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail,
                 input laser_enable, clear_fail, first_fault, fault_status, clear_timeout, state_out);
  modport slave(input arm_req, clear_req, pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail,
                output laser_enable, clear_fail, first_fault, fault_status, clear_timeout, state_out);
`endif
endinterface

// File: rtl/laser_interlock_ctrl_timer.sv
// interlock_timer: loadable down-counter that holds at zero
//   clk, rst : clock, synchronous active-high reset
//   load     : load load_val this cycle (wins over counting)
//   load_val : reload value
//   value    : current count
//   expired  : value is zero
module interlock_timer #(parameter int W = 10) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expired
);
  assign expired = value == '0;
  always_ff @(posedge clk)
    if (rst) value <= '0;
    else if (load) value <= load_val;
    else if (!expired) value <= value - W'(1);
endmodule

// File: rtl/laser_interlock_ctrl.sv
// laser_interlock_ctrl: laser-enable interlock with fault capture, clear_fail handshake and re-arm hold-off
//   clk, rst : clock, synchronous active-high reset
//   bus      : laser_interlock_ctrl_if.slave (arm/clear requests, checker fail flags, interlock outputs)
//   Macro LASER_INTLK_FAULT_CNT_EN adds saturating per-cause fault counters.
module laser_interlock_ctrl
  import laser_intlk_pkg::*;
#(
  parameter int CLR_PULSE_CYCLES = 8,
  parameter int CLR_TIMEOUT      = 256,
  parameter int HOLDOFF_CYCLES   = 1024
) (
  input logic clk,
  input logic rst,
  laser_interlock_ctrl_if.slave bus
);
  localparam int TW = tmr_w(CLR_TIMEOUT, HOLDOFF_CYCLES);
  state_t state;
  logic [2:0] fail_q;
  logic fail_any;
  logic tmr_load;
  logic tmr_expired;
  logic clear_done;
  logic [TW-1:0] tmr_val;
  logic [TW-1:0] tmr_value;
  assign fail_any = |fail_q;
  assign bus.laser_enable = state == S_ARMED && !fail_any;
  assign bus.state_out = state;
  // checker has recovered once the pulse is over and no flag remains
  assign clear_done = state == S_CLEARING && !bus.clear_fail && !fail_any;
  always_comb begin
    tmr_load = (state == S_TRIPPED && bus.clear_req) || clear_done;
    tmr_val = state == S_TRIPPED ? TW'(CLR_TIMEOUT - 1) : TW'(HOLDOFF_CYCLES - 1);
  end
  interlock_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .load(tmr_load), .load_val(tmr_val), .value(tmr_value), .expired(tmr_expired)
  );
  always_ff @(posedge clk)
    if (rst) fail_q <= '0;
    else begin
      fail_q[FLT_PW_LO] <= bus.pulse_lower_limit_fail;
      fail_q[FLT_PW_HI] <= bus.pulse_upper_limit_fail;
      fail_q[FLT_RATE]  <= bus.rate_lower_limit_fail;
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_DISARMED;
      bus.clear_fail <= 1'b0;
      bus.first_fault <= '0;
      bus.fault_status <= '0;
      bus.clear_timeout <= 1'b0;
    end else begin
      if (state != S_CLEARING) bus.fault_status <= bus.fault_status | fail_q;
      case (state)
        S_DISARMED:
          if (bus.arm_req) begin
            state <= fail_any ? S_TRIPPED : S_ARMED;
            if (fail_any) bus.first_fault <= fail_q;
          end
        S_ARMED, S_HOLDOFF:
          if (fail_any) begin
            state <= S_TRIPPED;
            bus.first_fault <= fail_q;
          end else if (state == S_HOLDOFF && tmr_expired) state <= S_DISARMED;
        S_TRIPPED:
          if (bus.clear_req) begin
            state <= S_CLEARING;
            bus.clear_fail <= 1'b1;
          end
        S_CLEARING: begin
          // timer was loaded with CLR_TIMEOUT-1 on entry, so the pulse covers the top CLR_PULSE_CYCLES counts
          bus.clear_fail <= tmr_value > TW'(CLR_TIMEOUT - CLR_PULSE_CYCLES);
          if (clear_done) begin
            state <= S_HOLDOFF;
            bus.fault_status <= '0;
            bus.clear_timeout <= 1'b0;
          end else if (tmr_expired) begin
            state <= S_TRIPPED;
            bus.clear_timeout <= 1'b1;
          end
        end
        default: state <= S_DISARMED;
      endcase
    end
`ifdef LASER_INTLK_FAULT_CNT_EN
  logic [2:0] fail_p;
  logic [2:0] rise;
  assign rise = fail_q & ~fail_p;
  always_ff @(posedge clk)
    if (rst) begin
      fail_p <= '0;
      bus.fault_cnt_lo <= '0;
      bus.fault_cnt_hi <= '0;
      bus.fault_cnt_rate <= '0;
    end else begin
      fail_p <= fail_q;
      if (rise[FLT_PW_LO] && !(&bus.fault_cnt_lo)) bus.fault_cnt_lo <= bus.fault_cnt_lo + 1'b1;
      if (rise[FLT_PW_HI] && !(&bus.fault_cnt_hi)) bus.fault_cnt_hi <= bus.fault_cnt_hi + 1'b1;
      if (rise[FLT_RATE] && !(&bus.fault_cnt_rate)) bus.fault_cnt_rate <= bus.fault_cnt_rate + 1'b1;
    end
`endif
endmodule
